// File: rtl/gpio_in_debounce.sv
// Per-channel two-flop synchronizer and debounce filter for GPIO pad inputs.
// Optional macro GPIO_DEB_EDGE_EN adds registered RISE/FALL/CHANGE_OR pulses.
module gpio_in_debounce #(
    parameter int IO_NUM     = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic [IO_NUM-1:0] PIN_RAW,
    output logic [IO_NUM-1:0] GPIO_IN_DEB,
    output logic [IO_NUM-1:0] RISE,
    output logic [IO_NUM-1:0] FALL,
    output logic              CHANGE_OR
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [IO_NUM-1:0] sync1_r;
    logic [IO_NUM-1:0] sync2_r;
    logic [IO_NUM-1:0] stable_r;
    logic [IO_NUM-1:0] accept_s;
    logic [IO_NUM-1:0] stable_next_s;

    // Two-flop synchronizer: the only logic that samples the raw pads.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            sync1_r <= {IO_NUM{1'b0}};
            sync2_r <= {IO_NUM{1'b0}};
        end else begin
            sync1_r <= PIN_RAW;
            sync2_r <= sync1_r;
        end
    end

    generate
        for (genvar i = 0; i < IO_NUM; i++) begin : g_chan
            logic [CNT_W-1:0] cnt_r;
            logic [CNT_W-1:0] cnt_next_s;
            logic             chan_accept_s;

            // Count consecutive disagreeing cycles; saturate into an acceptance.
            always_comb begin
                cnt_next_s    = CNT_ZERO;
                chan_accept_s = 1'b0;
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_next_s    = CNT_ZERO;
                    chan_accept_s = 1'b0;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_next_s    = CNT_ZERO;
                    chan_accept_s = 1'b1;
                end else begin
                    cnt_next_s    = cnt_r + CNT_ONE;
                    chan_accept_s = 1'b0;
                end
            end

            // Debounce counter register.
            always_ff @(posedge PCLK) begin
                if (!PRESETN) begin
                    cnt_r <= CNT_ZERO;
                end else begin
                    cnt_r <= cnt_next_s;
                end
            end

            assign accept_s[i] = chan_accept_s;
        end
    endgenerate

    // Accepted channels take the synchronized value; others hold.
    always_comb begin
        stable_next_s = (stable_r & ~accept_s) | (sync2_r & accept_s);
    end

    // Debounced level register.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            stable_r <= {IO_NUM{1'b0}};
        end else begin
            stable_r <= stable_next_s;
        end
    end

    assign GPIO_IN_DEB = stable_r;

`ifdef GPIO_DEB_EDGE_EN
    logic [IO_NUM-1:0] rise_r;
    logic [IO_NUM-1:0] fall_r;
    logic              change_r;

    // Edge pulses register on the same edge as the level, so they line up with it.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            rise_r   <= {IO_NUM{1'b0}};
            fall_r   <= {IO_NUM{1'b0}};
            change_r <= 1'b0;
        end else begin
            rise_r   <= accept_s & sync2_r;
            fall_r   <= accept_s & ~sync2_r;
            change_r <= |accept_s;
        end
    end

    assign RISE      = rise_r;
    assign FALL      = fall_r;
    assign CHANGE_OR = change_r;
`else
    assign RISE      = {IO_NUM{1'b0}};
    assign FALL      = {IO_NUM{1'b0}};
    assign CHANGE_OR = 1'b0;
`endif

endmodule
